// File: rtl/triangle_bbox_walker.sv
// Bounding-box walker: accepts one assembled triangle, clamps its x/y bounding box
// to the screen and presents every pixel of that box row-major to the edge tester.
module triangle_bbox_walker #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [143:0]   texel_vertices_in,
    input  logic [23:0]    texel_color_in,
    input  logic           texel_ready,
    output logic           texel_read,
    output logic [15:0]    pixel_x,
    output logic [15:0]    pixel_y,
    output logic [23:0]    pixel_color,
    output logic           pixel_valid,
    input  logic           pixel_ready,
    output logic           pixel_last,
    output logic           tri_done,
    output logic           busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WALK = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] X_LIM = 16'(SCREEN_W - 1);
    localparam logic [15:0] Y_LIM = 16'(SCREEN_H - 1);

    function automatic logic [15:0] min2(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [15:0] max2(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] min3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        return max2(max2(a, b), c);
    endfunction

    state_t        state_r, state_next_s;
    logic [143:0]  vert_r;
    logic [23:0]   color_r;
    logic [15:0]   xmin_r, xmax_r, ymin_r, ymax_r;
    logic [15:0]   x_r, y_r;
    logic          texel_read_r, pixel_valid_r, pixel_last_r, tri_done_r, busy_r;

    logic [15:0]   xmin_next_s, xmax_next_s, ymin_next_s, ymax_next_s;
    logic [15:0]   x_next_s, y_next_s;
    logic [15:0]   bxmin_s, bxmax_s, bymin_s, bymax_s;
    logic          load_s, last_next_s;

    // Bounding box of the latched triangle; vertex layout is {p,q,r} x {x,y,z}.
    always_comb begin
        bxmin_s = min3(vert_r[143:128], vert_r[95:80], vert_r[47:32]);
        bxmax_s = min2(max3(vert_r[143:128], vert_r[95:80], vert_r[47:32]), X_LIM);
        bymin_s = min3(vert_r[127:112], vert_r[79:64], vert_r[31:16]);
        bymax_s = min2(max3(vert_r[127:112], vert_r[79:64], vert_r[31:16]), Y_LIM);
    end

    // Next-state, walk counter and bbox register update logic.
    always_comb begin
        state_next_s = state_r;
        xmin_next_s  = xmin_r;
        xmax_next_s  = xmax_r;
        ymin_next_s  = ymin_r;
        ymax_next_s  = ymax_r;
        x_next_s     = x_r;
        y_next_s     = y_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (texel_ready) begin
                    state_next_s = ST_LOAD;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                xmin_next_s = bxmin_s;
                xmax_next_s = bxmax_s;
                ymin_next_s = bymin_s;
                ymax_next_s = bymax_s;
                x_next_s    = bxmin_s;
                y_next_s    = bymin_s;
                if ((bxmin_s > bxmax_s) || (bymin_s > bymax_s)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WALK;
                end
            end
            ST_WALK: begin
                if (pixel_ready) begin
                    if (x_r != xmax_r) begin
                        x_next_s = x_r + 16'd1;
                    end else if (y_r != ymax_r) begin
                        x_next_s = xmin_r;
                        y_next_s = y_r + 16'd1;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_WALK;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        last_next_s = (state_next_s == ST_WALK) && (x_next_s == xmax_next_s) &&
                      (y_next_s == ymax_next_s);
    end

    // State, datapath and registered outputs; outputs are decoded from the next state
    // so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r       <= ST_IDLE;
            vert_r        <= 144'd0;
            color_r       <= 24'd0;
            xmin_r        <= 16'd0;
            xmax_r        <= 16'd0;
            ymin_r        <= 16'd0;
            ymax_r        <= 16'd0;
            x_r           <= 16'd0;
            y_r           <= 16'd0;
            texel_read_r  <= 1'b0;
            pixel_valid_r <= 1'b0;
            pixel_last_r  <= 1'b0;
            tri_done_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (load_s) begin
                vert_r  <= texel_vertices_in;
                color_r <= texel_color_in;
            end
            xmin_r        <= xmin_next_s;
            xmax_r        <= xmax_next_s;
            ymin_r        <= ymin_next_s;
            ymax_r        <= ymax_next_s;
            x_r           <= x_next_s;
            y_r           <= y_next_s;
            texel_read_r  <= (state_next_s == ST_LOAD);
            pixel_valid_r <= (state_next_s == ST_WALK);
            pixel_last_r  <= last_next_s;
            tri_done_r    <= (state_next_s == ST_DONE);
            busy_r        <= (state_next_s != ST_IDLE);
        end
    end

    assign texel_read  = texel_read_r;
    assign pixel_x     = x_r;
    assign pixel_y     = y_r;
    assign pixel_color = color_r;
    assign pixel_valid = pixel_valid_r;
    assign pixel_last  = pixel_last_r;
    assign tri_done    = tri_done_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_triangle_bbox_walker.sv
// Directed bench for triangle_bbox_walker: reset, basic walk, backpressure,
// off-screen, clamping, degenerate triangle and reset during a walk.
module tb_triangle_bbox_walker;

    logic          tb_clk = 1'b0;
    logic          n_rst;
    logic [143:0]  texel_vertices_in;
    logic [23:0]   texel_color_in;
    logic          texel_ready;
    logic          texel_read;
    logic [15:0]   pixel_x;
    logic [15:0]   pixel_y;
    logic [23:0]   pixel_color;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          pixel_last;
    logic          tri_done;
    logic          busy;

    int total  = 0;
    int passed = 0;

    always #5 tb_clk = ~tb_clk;

    triangle_bbox_walker #(.SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk               (tb_clk),
        .n_rst             (n_rst),
        .texel_vertices_in (texel_vertices_in),
        .texel_color_in    (texel_color_in),
        .texel_ready       (texel_ready),
        .texel_read        (texel_read),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .pixel_color       (pixel_color),
        .pixel_valid       (pixel_valid),
        .pixel_ready       (pixel_ready),
        .pixel_last        (pixel_last),
        .tri_done          (tri_done),
        .busy              (busy)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [143:0] tri_pack(input logic [15:0] px, input logic [15:0] py,
                                              input logic [15:0] qx, input logic [15:0] qy,
                                              input logic [15:0] rx, input logic [15:0] ry);
        return {px, py, 16'd0, qx, qy, 16'd0, rx, ry, 16'd0};
    endfunction

    task automatic check_pixel(input string tag, input int x, input int y, input bit last,
                               input logic [23:0] c);
        check({tag, "_valid"}, pixel_valid, 1'b1);
        check({tag, "_x"}, pixel_x, x[15:0]);
        check({tag, "_y"}, pixel_y, y[15:0]);
        check({tag, "_last"}, pixel_last, last);
        check({tag, "_color"}, pixel_color, c);
        check({tag, "_noread"}, {texel_read, tri_done}, 2'b00);
    endtask

    // Sends one triangle and checks the whole expected pixel walk and completion.
    task automatic run_tri(input string tag, input logic [143:0] v, input logic [23:0] c,
                           input int xmin, input int xmax, input int ymin, input int ymax,
                           input bit bp, input bit hold);
        @(negedge tb_clk);
        texel_vertices_in = v;
        texel_color_in    = c;
        texel_ready       = 1'b1;
        pixel_ready       = 1'b1;
        @(negedge tb_clk);
        check({tag, "_load_read"}, texel_read, 1'b1);
        check({tag, "_load_valid"}, pixel_valid, 1'b0);
        check({tag, "_load_busy"}, busy, 1'b1);
        if (!hold) texel_ready = 1'b0;
        if ((xmin <= xmax) && (ymin <= ymax)) begin
            for (int y = ymin; y <= ymax; y++) begin
                for (int x = xmin; x <= xmax; x++) begin
                    @(negedge tb_clk);
                    check_pixel({tag, "_px"}, x, y, (x == xmax) && (y == ymax), c);
                    if (bp) begin
                        pixel_ready = 1'b0;
                        @(negedge tb_clk);
                        check_pixel({tag, "_frozen"}, x, y, (x == xmax) && (y == ymax), c);
                    end
                    pixel_ready = 1'b1;
                end
            end
        end
        @(negedge tb_clk);
        check({tag, "_done_pulse"}, tri_done, 1'b1);
        check({tag, "_done_valid"}, pixel_valid, 1'b0);
        check({tag, "_done_read"}, texel_read, 1'b0);
        texel_ready = 1'b0;
        @(negedge tb_clk);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_done"}, tri_done, 1'b0);
        check({tag, "_idle_read"}, texel_read, 1'b0);
    endtask

    initial begin
        n_rst             = 1'b0;
        texel_vertices_in = 144'd0;
        texel_color_in    = 24'd0;
        texel_ready       = 1'b0;
        pixel_ready       = 1'b0;

        // Reset held for two clocks
        repeat (2) @(negedge tb_clk);
        check("rst_outputs", {texel_read, pixel_valid, pixel_last, tri_done, busy}, 5'd0);
        check("rst_xy", {pixel_x, pixel_y}, 32'd0);
        check("rst_color", pixel_color, 24'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge tb_clk);
        check("idle_hold_busy", busy, 1'b0);
        check("idle_hold_read", texel_read, 1'b0);

        // Basic 3x3 box
        run_tri("basic", tri_pack(16'd2, 16'd3, 16'd4, 16'd3, 16'd3, 16'd5), 24'h112233,
                2, 4, 3, 5, 1'b0, 1'b0);

        // Same triangle under alternating backpressure
        run_tri("bp", tri_pack(16'd2, 16'd3, 16'd4, 16'd3, 16'd3, 16'd5), 24'h112233,
                2, 4, 3, 5, 1'b1, 1'b0);

        // Entirely right of the screen: empty box
        run_tri("offscreen", tri_pack(16'd640, 16'd0, 16'd700, 16'd5, 16'd1000, 16'd2),
                24'hABCDEF, 640, 639, 0, 5, 1'b0, 1'b0);

        // Clamped to the right edge, texel_ready held high throughout
        run_tri("clamp", tri_pack(16'd638, 16'd10, 16'd700, 16'd10, 16'd650, 16'd10),
                24'h445566, 638, 639, 10, 10, 1'b0, 1'b1);

        // Degenerate single-point triangle
        run_tri("degen", tri_pack(16'd5, 16'd7, 16'd5, 16'd7, 16'd5, 16'd7), 24'h0000FF,
                5, 5, 7, 7, 1'b0, 1'b0);

        // Reset while the fourth pixel is on the bus
        @(negedge tb_clk);
        texel_vertices_in = tri_pack(16'd2, 16'd3, 16'd4, 16'd3, 16'd3, 16'd5);
        texel_color_in    = 24'h778899;
        texel_ready       = 1'b1;
        pixel_ready       = 1'b1;
        @(negedge tb_clk);
        check("mid_load_read", texel_read, 1'b1);
        texel_ready = 1'b0;
        repeat (4) @(negedge tb_clk);
        check_pixel("mid_px4", 2, 4, 1'b0, 24'h778899);
        n_rst = 1'b0;
        @(negedge tb_clk);
        check("mid_rst_valid", pixel_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", tri_done, 1'b0);
        n_rst = 1'b1;
        @(negedge tb_clk);
        check("mid_after_done", tri_done, 1'b0);
        check("mid_after_busy", busy, 1'b0);
        run_tri("after_rst", tri_pack(16'd10, 16'd20, 16'd11, 16'd21, 16'd10, 16'd21),
                24'h010203, 10, 11, 20, 21, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
